// File: rtl/sumador_pkg.sv
// Shared constants, stage-count helper and per-stage control record for the
// segmented pipelined adder.
package sumador_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SEG_W_DEF = 16;

  function automatic int num_stages(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Control travelling with each slot; the segment sums ride alongside it,
  // sized per stage.
  typedef struct packed {
    logic valid;
    logic op_sub;
    logic carry;
  } stage_t;

endpackage

// File: rtl/sumador_n_bits.sv
// Combinational W-bit adder slice; also exposes the carry into its MSB so the
// last slice can flag two's-complement overflow.
module sumador_n_bits #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         c_msb_o
);

  logic [W:0] full;

  assign full    = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign sum_o   = full[W-1:0];
  assign cout_o  = full[W];
  // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
  assign c_msb_o = a_i[W-1] ^ b_i[W-1] ^ sum_o[W-1];

endmodule

// File: rtl/sumador_segmentado.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG_W-bit slice per stage, carry
// registered between stages, valid/ready handshake with full back-pressure.
module sumador_segmentado
  import sumador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = num_stages(WIDTH, SEG_W);

  if ((WIDTH % SEG_W) != 0 || STAGES < 1) begin : g_param_chk
    $error("sumador_segmentado: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t                   ctl_q, ctl_d;
    logic [(k+1)*SEG_W-1:0]   sum_q, sum_d;
    logic [SEG_W-1:0]         a_seg, b_raw, b_seg, s_seg;
    logic                     op_sub_k, valid_in, c_in, c_out, c_msb;

    // Stage 0 works straight off the ports; later stages off the skew registers.
    if (k == 0) begin : g_src
      assign a_seg    = a[SEG_W-1:0];
      assign b_raw    = b[SEG_W-1:0];
      assign op_sub_k = op_sub;
      assign valid_in = in_valid;
      assign c_in     = op_sub | cin;
      assign sum_d    = s_seg;
    end else begin : g_src
      assign a_seg    = g_st[k-1].g_skew.a_q[SEG_W-1:0];
      assign b_raw    = g_st[k-1].g_skew.b_q[SEG_W-1:0];
      assign op_sub_k = g_st[k-1].ctl_q.op_sub;
      assign valid_in = g_st[k-1].ctl_q.valid;
      assign c_in     = g_st[k-1].ctl_q.carry;
      assign sum_d    = {s_seg, g_st[k-1].sum_q};
    end

    assign b_seg = b_raw ^ {SEG_W{op_sub_k}};

    sumador_n_bits #(.W(SEG_W)) u_add (
      .a_i    (a_seg),
      .b_i    (b_seg),
      .cin_i  (c_in),
      .sum_o  (s_seg),
      .cout_o (c_out),
      .c_msb_o(c_msb)
    );

    assign ctl_d = '{valid: valid_in, op_sub: op_sub_k, carry: c_out};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (adv) begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
      end
    end

    // Upper operand segments not yet consumed, shifted down one slice per stage.
    if (k < STAGES-1) begin : g_skew
      logic [WIDTH-(k+1)*SEG_W-1:0] a_q, b_q, a_d, b_d;

      if (k == 0) begin : g_skew_src
        assign a_d = a[WIDTH-1:SEG_W];
        assign b_d = b[WIDTH-1:SEG_W];
      end else begin : g_skew_src
        assign a_d = g_st[k-1].g_skew.a_q[WIDTH-k*SEG_W-1:SEG_W];
        assign b_d = g_st[k-1].g_skew.b_q[WIDTH-k*SEG_W-1:SEG_W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES-1) begin : g_last
      logic ovf_q, ovf_d, op_unused;

      assign ovf_d     = c_msb ^ c_out;
      assign op_unused = ctl_q.op_sub;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
      end
    end else begin : g_mid
      logic msb_unused;
      assign msb_unused = c_msb;
    end
  end

  assign out_valid = g_st[STAGES-1].ctl_q.valid;
  assign cout      = g_st[STAGES-1].ctl_q.carry;
  assign sum       = g_st[STAGES-1].sum_q;
  assign overflow  = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_sumador_segmentado.sv
// Directed bench for sumador_segmentado (64-bit, 16-bit segments, latency 4).
module tb_sumador_segmentado;

  localparam int W = 64;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, cin = 1'b0, op_sub = 1'b0;
  logic         out_valid, out_ready = 1'b1, cout, overflow;
  logic [W-1:0] a = '0, b = '0, sum;
  int           n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  sumador_segmentado #(.WIDTH(64), .SEG_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  // Returns {overflow, cout, sum}; overflow from the operand/result sign rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic op);
    logic [W-1:0] yy;
    logic [W:0]   f;
    logic         ov;
    yy = op ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (op | ci)};
    ov = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
    return {ov, f[W], f[W-1:0]};
  endfunction

  task automatic send_one(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                          input logic top, output logic [W-1:0] s, output logic c,
                          output logic o, output int lat);
    @(negedge clk);
    a = ta; b = tbv; cin = tc; op_sub = top; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = sum; c = cout; o = overflow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (sum !== '0)         begin n_fail++; $display("FAIL reset_sum: got %0h want 0", sum); end
    n_checks++; if (cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] s; logic c, o; int lat;
    send_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s, c, o, lat);
    n_checks++; if (lat !== 4)    begin n_fail++; $display("FAIL carry_latency: got %0d want 4", lat); end
    n_checks++; if (s !== 64'h0)  begin n_fail++; $display("FAIL carry_sum: got %0h want 0", s); end
    n_checks++; if (c !== 1'b1)   begin n_fail++; $display("FAIL carry_cout: got %b want 1", c); end
    n_checks++; if (o !== 1'b0)   begin n_fail++; $display("FAIL carry_ovf: got %b want 0", o); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s; logic c, o; int lat;
    send_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s, c, o, lat);
    n_checks++; if (s !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovf_sum: got %0h want 8000000000000000", s); end
    n_checks++; if (c !== 1'b0)   begin n_fail++; $display("FAIL ovf_cout: got %b want 0", c); end
    n_checks++; if (o !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag: got %b want 1", o); end
    n_checks++; if (lat !== 4)    begin n_fail++; $display("FAIL ovf_latency: got %0d want 4", lat); end
  endtask

  task automatic test_subtract();
    logic [W-1:0] s; logic c, o; int lat;
    send_one(64'd5, 64'd7, 1'b1, 1'b1, s, c, o, lat);
    n_checks++; if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub_neg_sum: got %0h want fffffffffffffffe", s); end
    n_checks++; if (c !== 1'b0)   begin n_fail++; $display("FAIL sub_neg_cout: got %b want 0", c); end
    n_checks++; if (o !== 1'b0)   begin n_fail++; $display("FAIL sub_neg_ovf: got %b want 0", o); end
    send_one(64'd7, 64'd5, 1'b0, 1'b1, s, c, o, lat);
    n_checks++; if (s !== 64'd2)  begin n_fail++; $display("FAIL sub_pos_sum: got %0h want 2", s); end
    n_checks++; if (c !== 1'b1)   begin n_fail++; $display("FAIL sub_pos_cout: got %b want 1", c); end
    n_checks++; if (o !== 1'b0)   begin n_fail++; $display("FAIL sub_pos_ovf: got %b want 0", o); end
  endtask

  // Continuous input; consumer stalls in cycles 5..7 while the pipe is full.
  task automatic test_back_to_back();
    logic [W-1:0] va[8], vb[8];
    logic         vc[8], vo[8];
    logic [W+1:0] ex[8];
    int           idx, nrx;
    logic         stall;
    for (int i = 0; i < 8; i++) begin
      va[i] = {$urandom, $urandom}; vb[i] = {$urandom, $urandom};
      vc[i] = 1'($urandom_range(1)); vo[i] = 1'($urandom_range(1));
      ex[i] = model(va[i], vb[i], vc[i], vo[i]);
    end
    idx = 0; nrx = 0;
    for (int cyc = 0; cyc < 40 && nrx < 8; cyc++) begin
      @(negedge clk);
      stall = (cyc >= 5 && cyc <= 7);
      out_ready = ~stall;
      if (idx < 8) begin
        in_valid = 1'b1; a = va[idx]; b = vb[idx]; cin = vc[idx]; op_sub = vo[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_checks++; if (in_ready !== ~stall) begin n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b want %b", cyc, in_ready, ~stall); end
      if (stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || sum !== ex[1][W-1:0]) begin
          n_fail++; $display("FAIL b2b_hold cyc %0d: got v=%b sum=%0h want v=1 sum=%0h", cyc, out_valid, sum, ex[1][W-1:0]);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if ({overflow, cout, sum} !== ex[nrx]) begin
          n_fail++; $display("FAIL b2b_result %0d: got %0h want %0h", nrx, {overflow, cout, sum}, ex[nrx]);
        end
        nrx++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (nrx !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", nrx); end
  endtask

  // out_ready alternates each cycle; results must come out every second cycle.
  task automatic test_toggle();
    logic [W-1:0] va[8], vb[8];
    logic [W+1:0] ex[8];
    int           idx, nrx, last_cyc;
    for (int i = 0; i < 8; i++) begin
      va[i] = 64'h1111_1111_1111_1111 * (i + 1);
      vb[i] = 64'(i);
      ex[i] = model(va[i], vb[i], 1'(i % 2), 1'(i == 3));
    end
    idx = 0; nrx = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 60 && nrx < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'(cyc % 2);
      if (idx < 8) begin
        in_valid = 1'b1; a = va[idx]; b = vb[idx]; cin = 1'(idx % 2); op_sub = 1'(idx == 3);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if ({overflow, cout, sum} !== ex[nrx]) begin
          n_fail++; $display("FAIL toggle_result %0d: got %0h want %0h", nrx, {overflow, cout, sum}, ex[nrx]);
        end
        if (last_cyc >= 0) begin
          n_checks++; if (cyc - last_cyc !== 2) begin n_fail++; $display("FAIL toggle_gap %0d: got %0d want 2", nrx, cyc - last_cyc); end
        end
        last_cyc = cyc;
        nrx++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (nrx !== 8) begin n_fail++; $display("FAIL toggle_count: got %0d want 8", nrx); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL toggle_extra: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s; logic c, o; int lat, stale;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 64'(i + 1); b = 64'(i + 1); cin = 1'b0; op_sub = 1'b0;
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || sum !== 64'd2) begin n_fail++; $display("FAIL midrst_pre: got v=%b sum=%0h want v=1 sum=2", out_valid, sum); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: got v=%b sum=%0h c=%b o=%b want all 0", out_valid, sum, cout, overflow);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL midrst_stale: got %0d stale cycles want 0", stale); end
    send_one(64'd0, 64'd0, 1'b1, 1'b0, s, c, o, lat);
    n_checks++; if (s !== 64'd1) begin n_fail++; $display("FAIL midrst_fresh_sum: got %0h want 1", s); end
    n_checks++; if (lat !== 4)   begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d want 4", lat); end
    n_checks++; if (c !== 1'b0 || o !== 1'b0) begin n_fail++; $display("FAIL midrst_fresh_flags: got c=%b o=%b want 0 0", c, o); end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_toggle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
